// File: rtl/pc_unit.sv
// Program counter stage: owns the 16-bit PC, the jump/relative holding registers
// and the external code-address latch driven by ALE.
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          AW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Phase,
  input  logic [2:0]    PC_CON,
  input  logic          jmpH_en,
  input  logic          jmpL_en,
  input  logic          rel_en,
  input  logic [7:0]    bus_in,
  input  logic          ALE,
  output logic [AW-1:0] PC,
  output logic [AW-1:0] code_addr,
  output logic [7:0]    P2_addr,
  output logic [7:0]    P0_addr,
  output logic          addr_valid,
  output logic          pc_wrap,
  output logic [1:0]    fsm_state
);

  // Handshake: none; every register advances on a clk edge with Phase==1 ("step"),
  // except the ALE sampler and latch FSM which run every clk.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    HOLD    = 2'd2
  } lat_state_t;

  lat_state_t state, state_next;
  logic       latch_now;
  logic       ale_q;

  logic [7:0]    jmph_q, jmpl_q, rel_q;
  logic [7:0]    jmph_eff, jmpl_eff, rel_eff;
  logic [AW-1:0] rel_ext;
  logic [AW-1:0] pc_next;
  logic          wrap_next;
  logic          pc_en, jump_flag, add_rel;

  assign pc_en     = PC_CON[2];
  assign jump_flag = PC_CON[1];
  assign add_rel   = PC_CON[0];

  // Same-step bypass lets a jump use the operand byte fetched on that step.
  assign jmph_eff = jmpH_en ? bus_in : jmph_q;
  assign jmpl_eff = jmpL_en ? bus_in : jmpl_q;
  assign rel_eff  = rel_en  ? bus_in : rel_q;
  assign rel_ext  = {{(AW-8){rel_eff[7]}}, rel_eff};

  always_comb begin
    pc_next   = PC + 1'b1;
    wrap_next = (PC == {AW{1'b1}});
    if (jump_flag) begin
      wrap_next = 1'b0;
      if (add_rel) pc_next = PC + rel_ext;
      else         pc_next = {jmph_eff, jmpl_eff};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC      <= RESET_PC;
      jmph_q  <= 8'h00;
      jmpl_q  <= 8'h00;
      rel_q   <= 8'h00;
      pc_wrap <= 1'b0;
    end else if (Phase) begin
      if (jmpH_en) jmph_q <= bus_in;
      if (jmpL_en) jmpl_q <= bus_in;
      if (rel_en)  rel_q  <= bus_in;
      if (pc_en)   PC     <= pc_next;
      pc_wrap <= pc_en & wrap_next;
    end else begin
      pc_wrap <= 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    latch_now  = 1'b0;
    case (state)
      IDLE: begin
        if (ALE && !ale_q) begin
          latch_now  = 1'b1;
          state_next = LATCHED;
        end
      end
      LATCHED: state_next = ALE ? HOLD : IDLE;
      HOLD:    state_next = ALE ? HOLD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ale_q      <= 1'b0;
      code_addr  <= '0;
      addr_valid <= 1'b0;
    end else begin
      state <= state_next;
      ale_q <= ALE;
      if (latch_now) begin
        code_addr  <= PC;
        addr_valid <= 1'b1;
      end
    end
  end

  assign P2_addr   = code_addr[15:8];
  assign P0_addr   = code_addr[7:0];
  assign fsm_state = state;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter stage sitting directly downstream of the control unit.
- Consumes the control unit's PC_CON, jmpH_en/jmpL_en/rel_en and ALE strobes.
- Owns the 16-bit PC, the jump-target and relative-offset holding registers, and the external code-address latch (high byte to P2, low byte to P0).
- Produces the fetch address for code memory and a wrap flag.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- AW, 16, PC/address width; fixed at 16, others unsupported.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- Phase  input  1  phase from control unit; register updates qualified by Phase==1 ("step").
- PC_CON  input  3  {PC_en, Jump_flag, PC_add_rel}.
- jmpH_en  input  1  capture bus_in into jump-target high byte.
- jmpL_en  input  1  capture bus_in into jump-target low byte.
- rel_en  input  1  capture bus_in into relative offset.
- bus_in  input  8  internal data bus (code byte just fetched).
- ALE  input  1  address latch enable from control unit, high active.
- PC  output  16  current program counter.
- code_addr  output  16  latched external code address.
- P2_addr  output  8  code_addr[15:8].
- P0_addr  output  8  code_addr[7:0].
- addr_valid  output  1  high from first latch after reset onward.
- pc_wrap  output  1  one-step pulse when PC wraps FFFF->0000.

Behaviour:
- Reset (reset==0, asynchronous):
  - PC=RESET_PC; jmpH=jmpL=rel=0; code_addr=0; addr_valid=0; pc_wrap=0.
  - ALE edge-detect register cleared to 0; FSM to IDLE.
- Step = rising clk with Phase==1. With Phase==0, all registers hold; pc_wrap clears to 0.
- Holding registers on a step: jmpH<=bus_in if jmpH_en; jmpL<=bus_in if jmpL_en; rel<=bus_in if rel_en. Enables are independent; several may be active in one step.
- PC update on a step with PC_en==1, decoded from {Jump_flag, PC_add_rel}:
  - 00: PC<=PC+1.
  - 10: PC<={jmpH_eff, jmpL_eff}.
  - 11: PC<=PC+sign_extend(rel_eff), modulo 2^16.
  - 01: reserved; behaves as 00.
- Bypass: jmpH_eff/jmpL_eff/rel_eff equal bus_in when the matching enable is active in the same step, else the stored register. Example: LJMP low byte and jump in one step uses the new byte.
- PC_en==0: PC holds regardless of Jump_flag/PC_add_rel.
- Arithmetic:
  - Increment and relative add are 16-bit with wrap; no carry out.
  - rel is two's complement, -128..+127.
  - pc_wrap=1 for one step only when the increment path takes FFFF->0000. Not asserted for jumps or relative adds.
- Address latch FSM:
  - States IDLE, LATCHED, HOLD. ALE is sampled every clk (not Phase-qualified).
  - IDLE: ALE rising (prev 0, now 1) -> code_addr<=PC, addr_valid<=1, go LATCHED.
  - LATCHED: ALE still 1 -> HOLD; ALE 0 -> IDLE.
  - HOLD: ALE 0 -> IDLE; code_addr frozen while ALE stays high.
  - Only one latch per ALE pulse.
  - If a PC update and an ALE rising edge occur on the same clk, code_addr takes the pre-update PC.
- P2_addr/P0_addr are continuous slices of code_addr; no extra latency.
- Reset mid-operation: immediate return to reset values. Any partial ALE pulse in flight is ignored until ALE returns low and rises again; the edge detector is cleared to 0, so ALE held high at reset release gives one latch.
- Latency:
  - PC visible one clk after the qualifying step.
  - code_addr visible one clk after the ALE rising sample.

Test Plan:
- Reset release, 4 steps with PC_CON=100 -> PC 0000,0001,0002,0003,0004; pc_wrap stays 0; no latch until ALE.
- Force PC=FFFE via jump, two increments -> PC FFFF then 0000; pc_wrap=1 for exactly the second step.
- jmpH_en with bus_in=12, then a step with jmpL_en, bus_in=34 and PC_CON=110 together -> PC=1234 (bypass).
- PC=0100, rel_en with bus_in=FE in the same step as PC_CON=111 -> PC=00FE. Repeat with rel=7F from PC=FFF0 -> PC=006F, pc_wrap=0.
- PC=ABCD, ALE high for 3 clks with an increment on the first clk -> code_addr=ABCD, P2=AB, P0=CD, single latch. Next ALE pulse -> ABCE.
- Assert reset during ALE high with PC=5555 -> all outputs zero immediately. After release with ALE still high, code_addr=RESET_PC on the next clk.
